hdr_lock_aligner: RTL

- Parametrised successor to the fixed 66b header aligner.
- Each valid window, it scores every candidate header offset of a BLOCK_W-bit block with a saturating run-length counter and finds the best offset through a radix-4 registered argmax tree.
- A HUNT/LOCKED state machine declares lock, then monitors the locked offset for bad headers and drops lock on excessive errors.
- Sits between the gearbox buffer slicer and the block descrambler/decoder.

---
 rtl/hdr_lock_aligner_pkg.sv | 31 +++
 rtl/hdr_lock_aligner_argmax4_tree.sv | 96 +++++++++
 rtl/hdr_lock_aligner.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hdr_lock_aligner_pkg.sv
// Shared definitions for the header lock aligner: header codes, lock FSM
// states and helpers for sizing the argmax tree.
package hdr_align_pkg;

    localparam logic [1:0] DATA_HDR = 2'b01;
    localparam logic [1:0] CMD_HDR  = 2'b10;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Number of radix-4 levels needed to reduce n candidates to one (at least 1).
    function automatic int unsigned tree_levels(input int unsigned n);
        int unsigned lv;
        int unsigned span;
        lv   = 0;
        span = 1;
        while (span < n) begin
            span = span * 4;
            lv   = lv + 1;
        end
        return (lv == 0) ? 1 : lv;
    endfunction

    // A sync header is valid only when its two bits differ.
    function automatic logic hdr_ok(input logic [1:0] p);
        return (p == DATA_HDR) || (p == CMD_HDR);
    endfunction

endpackage

// File: rtl/hdr_lock_aligner_argmax4_tree.sv
// Registered radix-4 argmax over N counters. One register level per radix-4
// reduction; strict greater-than so the lowest index wins ties.
// Ports:
//   clk, rst   clock, async active-high reset
//   flush      synchronous clear of every valid bit in the pipe
//   in_valid   counters on cnt are a fresh result
//   cnt        N packed counters, index k at cnt[k*CNT_W +: CNT_W]
//   out_valid  max_cnt/max_off carry a result
//   max_cnt    winning count
//   max_off    index of the winning counter
module argmax4_tree
    import hdr_align_pkg::*;
#(
    parameter int unsigned N     = 66,
    parameter int unsigned CNT_W = 6,
    parameter int unsigned OFF_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [N*CNT_W-1:0]   cnt,
    output logic                 out_valid,
    output logic [CNT_W-1:0]     max_cnt,
    output logic [OFF_W-1:0]     max_off
);

    localparam int unsigned L = tree_levels(N);
    localparam int unsigned P = 1 << (2 * L);

    for (genvar g = 0; g <= L; g++) begin : lvl
        localparam int unsigned W = P >> (2 * g);
        logic [CNT_W-1:0] c [W];
        logic [OFF_W-1:0] o [W];
        logic             v;

        if (g == 0) begin : leaf
            // Pad to a power of four with zero counts; padding sits above the
            // real indices so it can never win under strict greater-than.
            for (genvar i = 0; i < W; i++) begin : pad
                if (i < N) begin : used
                    assign c[i] = cnt[i*CNT_W +: CNT_W];
                    assign o[i] = OFF_W'(i);
                end else begin : unused
                    assign c[i] = '0;
                    assign o[i] = '0;
                end
            end
            assign v = in_valid;
        end else begin : node
            logic [CNT_W-1:0] c_d [W];
            logic [OFF_W-1:0] o_d [W];
            logic [CNT_W-1:0] bc;
            logic [OFF_W-1:0] bo;

            // Pick the best of each group of four children.
            always_comb begin
                bc = '0;
                bo = '0;
                for (int n = 0; n < int'(W); n++) begin
                    bc = lvl[g-1].c[4*n];
                    bo = lvl[g-1].o[4*n];
                    for (int j = 1; j < 4; j++) begin
                        if (lvl[g-1].c[4*n+j] > bc) begin
                            bc = lvl[g-1].c[4*n+j];
                            bo = lvl[g-1].o[4*n+j];
                        end
                    end
                    c_d[n] = bc;
                    o_d[n] = bo;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v <= 1'b0;
                    for (int n = 0; n < int'(W); n++) begin
                        c[n] <= '0;
                        o[n] <= '0;
                    end
                end else begin
                    v <= flush ? 1'b0 : lvl[g-1].v;
                    for (int n = 0; n < int'(W); n++) begin
                        c[n] <= c_d[n];
                        o[n] <= o_d[n];
                    end
                end
            end
        end
    end

    assign out_valid = lvl[L].v;
    assign max_cnt   = lvl[L].c[0];
    assign max_off   = lvl[L].o[0];

endmodule

// File: rtl/hdr_lock_aligner.sv
// Block header lock aligner. Scores every candidate header offset with a
// saturating run-length counter, locks on the best offset once its run
// reaches LOCK_THRESH, then watches the locked offset for bad headers.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   win_i             BLOCK_W+1 bit slice; candidate k uses win_i[k+1:k]
//   win_dv_i          win_i valid
//   force_relock_i    single-cycle request to return to HUNT
//   block_offset_o    locked header offset
//   locked_o          lock status
//   lock_evt_o        pulse on HUNT->LOCKED
//   unlock_evt_o      pulse on LOCKED->HUNT
//   bad_hdr_cnt_o     bad headers in the current monitoring window
module hdr_lock_aligner
    import hdr_align_pkg::*;
#(
    parameter int unsigned BLOCK_W       = 66,
    parameter int unsigned CNT_W         = 6,
    parameter int unsigned LOCK_THRESH   = 32,
    parameter int unsigned MON_WINDOW    = 64,
    parameter int unsigned UNLOCK_THRESH = 8,
    parameter int unsigned OFF_W         = $clog2(BLOCK_W),
    localparam int unsigned BAD_W        = $clog2(UNLOCK_THRESH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [BLOCK_W:0]   win_i,
    input  logic               win_dv_i,
    input  logic               force_relock_i,
    output logic [OFF_W-1:0]   block_offset_o,
    output logic               locked_o,
    output logic               lock_evt_o,
    output logic               unlock_evt_o,
    output logic [BAD_W-1:0]   bad_hdr_cnt_o
);

    localparam int unsigned BLK_W = (MON_WINDOW > 1) ? $clog2(MON_WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [BLOCK_W:0]         win_q;
    logic                     dv_q;
    logic [BLOCK_W*CNT_W-1:0] cnt;
    logic [BLOCK_W*CNT_W-1:0] cnt_d;
    logic                     cnt_vld;
    logic                     flush_c;

    logic                     tree_vld;
    logic [CNT_W-1:0]         tree_max;
    logic [OFF_W-1:0]         tree_off;

    state_t                   state, state_d;
    logic                     locked_d, lock_evt_d, unlock_evt_d;
    logic [OFF_W-1:0]         off_d;
    logic [BAD_W-1:0]         bad_d;
    logic [BLK_W-1:0]         blk_cnt, blk_d;
    logic                     hdr_bad_c;

    // Run-length scoring of every candidate offset.
    always_comb begin
        cnt_d = cnt;
        for (int unsigned k = 0; k < BLOCK_W; k++) begin
            if (!hdr_ok(win_q[k +: 2])) begin
                cnt_d[k*CNT_W +: CNT_W] = '0;
            end else if (cnt[k*CNT_W +: CNT_W] != CNT_MAX) begin
                cnt_d[k*CNT_W +: CNT_W] = cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q   <= '0;
            dv_q    <= 1'b0;
            cnt     <= '0;
            cnt_vld <= 1'b0;
        end else begin
            win_q <= win_i;
            dv_q  <= win_dv_i;
            if (flush_c) begin
                cnt     <= '0;
                cnt_vld <= 1'b0;
            end else begin
                cnt_vld <= dv_q;
                if (dv_q) begin
                    cnt <= cnt_d;
                end
            end
        end
    end

    argmax4_tree #(
        .N     (BLOCK_W),
        .CNT_W (CNT_W),
        .OFF_W (OFF_W)
    ) u_tree (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (flush_c),
        .in_valid  (cnt_vld),
        .cnt       (cnt),
        .out_valid (tree_vld),
        .max_cnt   (tree_max),
        .max_off   (tree_off)
    );

    // Lock FSM next-state and outputs. A relock request overrides a
    // same-cycle lock decision.
    always_comb begin
        state_d      = state;
        locked_d     = locked_o;
        lock_evt_d   = 1'b0;
        unlock_evt_d = 1'b0;
        off_d        = block_offset_o;
        bad_d        = bad_hdr_cnt_o;
        blk_d        = blk_cnt;
        flush_c      = 1'b0;
        hdr_bad_c    = !hdr_ok(win_q[block_offset_o +: 2]);

        case (state)
            HUNT: begin
                if (force_relock_i) begin
                    flush_c = 1'b1;
                end else if (tree_vld && (tree_max >= CNT_W'(LOCK_THRESH))) begin
                    state_d    = LOCKED;
                    locked_d   = 1'b1;
                    lock_evt_d = 1'b1;
                    off_d      = tree_off;
                    bad_d      = '0;
                    blk_d      = '0;
                end
            end
            LOCKED: begin
                if (force_relock_i || (bad_hdr_cnt_o >= BAD_W'(UNLOCK_THRESH))) begin
                    state_d      = HUNT;
                    locked_d     = 1'b0;
                    unlock_evt_d = 1'b1;
                    flush_c      = 1'b1;
                    bad_d        = '0;
                    blk_d        = '0;
                end else if (dv_q) begin
                    // The wrap block's own bad header counts into the new window.
                    if (blk_cnt == BLK_W'(MON_WINDOW - 1)) begin
                        blk_d = '0;
                        bad_d = hdr_bad_c ? BAD_W'(1) : '0;
                    end else begin
                        blk_d = blk_cnt + BLK_W'(1);
                        if (hdr_bad_c) begin
                            bad_d = bad_hdr_cnt_o + BAD_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= HUNT;
            locked_o       <= 1'b0;
            lock_evt_o     <= 1'b0;
            unlock_evt_o   <= 1'b0;
            block_offset_o <= '0;
            bad_hdr_cnt_o  <= '0;
            blk_cnt        <= '0;
        end else begin
            state          <= state_d;
            locked_o       <= locked_d;
            lock_evt_o     <= lock_evt_d;
            unlock_evt_o   <= unlock_evt_d;
            block_offset_o <= off_d;
            bad_hdr_cnt_o  <= bad_d;
            blk_cnt        <= blk_d;
        end
    end

endmodule
